// File: rtl/pipe_scroller.sv
// Two-pipe obstacle scroller: moves pipes left once per frame tick, respawns them
// off-screen right with an LFSR-derived gap height, and keeps the cleared-pipe score.
module pipe_scroller #(
    parameter int RESPAWN_X    = 710,
    parameter int PIPE_SPACING = 355,
    parameter int SPEED        = 2,
    parameter int BIRD_X       = 100,
    parameter int GAP_BASE     = 150,
    parameter int PIPE1_Y0     = 240,
    parameter int PIPE2_Y0     = 320
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        restart,
    input  logic        collision,
    output logic [10:0] pipe1_x,
    output logic [10:0] pipe1_y,
    output logic [10:0] pipe2_x,
    output logic [10:0] pipe2_y,
    output logic        score_pulse,
    output logic [7:0]  score,
    output logic        running
);

    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic [10:0] X1_INIT  = 11'(RESPAWN_X);
    localparam logic [10:0] X2_INIT  = 11'(RESPAWN_X + PIPE_SPACING);
    localparam logic [10:0] Y1_INIT  = 11'(PIPE1_Y0);
    localparam logic [10:0] Y2_INIT  = 11'(PIPE2_Y0);
    localparam logic [10:0] SPEED_C  = 11'(SPEED);
    localparam logic [10:0] BIRD_X_C = 11'(BIRD_X);
    localparam logic [10:0] GAP_C    = 11'(GAP_BASE);
    localparam logic [7:0]  LFSR_SEED = 8'hA5;

    logic [1:0]  state_q, state_d;
    logic [10:0] p1x_q, p1x_d, p1y_q, p1y_d;
    logic [10:0] p2x_q, p2x_d, p2y_q, p2y_d;
    logic [7:0]  score_q, score_d;
    logic        pulse_q, pulse_d;
    logic [7:0]  lfsr_q, lfsr_d;

    logic        move;
    logic        respawn1, respawn2;
    logic        cross1, cross2;
    logic [10:0] gap_y;

    function automatic logic crossed(input logic [10:0] x);
        return (x >= BIRD_X_C) && (x >= SPEED_C) && ((x - SPEED_C) < BIRD_X_C);
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] s, input logic [1:0] n);
        logic [8:0] sum;
        sum = {1'b0, s} + {7'd0, n};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running in every state.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    assign gap_y    = GAP_C + {3'b000, lfsr_q};
    assign respawn1 = (p1x_q < SPEED_C);
    assign respawn2 = (p2x_q < SPEED_C);
    assign cross1   = crossed(p1x_q);
    assign cross2   = crossed(p2x_q);

    // Collision takes priority over a simultaneous frame tick.
    assign move = (state_q == ST_RUN) && !restart && !collision && frame_tick;

    always_comb begin
        state_d = state_q;
        p1x_d   = p1x_q;
        p1y_d   = p1y_q;
        p2x_d   = p2x_q;
        p2y_d   = p2y_q;
        score_d = score_q;
        pulse_d = 1'b0;

        if (restart) begin
            state_d = ST_WAIT;
            p1x_d   = X1_INIT;
            p1y_d   = Y1_INIT;
            p2x_d   = X2_INIT;
            p2y_d   = Y2_INIT;
            score_d = 8'd0;
        end else begin
            case (state_q)
                ST_WAIT: if (start) state_d = ST_RUN;
                ST_RUN:  if (collision) state_d = ST_STOP;
                ST_STOP: state_d = ST_STOP;
                default: state_d = ST_WAIT;
            endcase
        end

        if (move) begin
            if (respawn1) begin
                p1x_d = X1_INIT;
                p1y_d = gap_y;
            end else begin
                p1x_d = p1x_q - SPEED_C;
            end
            if (respawn2) begin
                p2x_d = X1_INIT;
                p2y_d = gap_y;
            end else begin
                p2x_d = p2x_q - SPEED_C;
            end
            // Both crossings on one tick share a single pulse but count twice.
            score_d = sat_add(score_q, {1'b0, cross1} + {1'b0, cross2});
            pulse_d = cross1 | cross2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WAIT;
            p1x_q   <= X1_INIT;
            p1y_q   <= Y1_INIT;
            p2x_q   <= X2_INIT;
            p2y_q   <= Y2_INIT;
            score_q <= 8'd0;
            pulse_q <= 1'b0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            p1x_q   <= p1x_d;
            p1y_q   <= p1y_d;
            p2x_q   <= p2x_d;
            p2y_q   <= p2y_d;
            score_q <= score_d;
            pulse_q <= pulse_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign pipe1_x     = p1x_q;
    assign pipe1_y     = p1y_q;
    assign pipe2_x     = p2x_q;
    assign pipe2_y     = p2y_q;
    assign score       = score_q;
    assign score_pulse = pulse_q;
    assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_pipe_scroller.sv
// Bench for pipe_scroller: behavioural game model compared every cycle, plus
// hand-computed checkpoints for the scripted scenarios.
module tb_pipe_scroller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        restart = 1'b0;
    logic        collision = 1'b0;
    logic [10:0] pipe1_x, pipe1_y, pipe2_x, pipe2_y;
    logic        score_pulse;
    logic [7:0]  score;
    logic        running;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // model state: mode 0=waiting, 1=running, 2=stopped
    int m_mode, m_p1x, m_p1y, m_p2x, m_p2y, m_score, m_pulse, m_lfsr;

    pipe_scroller dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .restart(restart), .collision(collision),
        .pipe1_x(pipe1_x), .pipe1_y(pipe1_y), .pipe2_x(pipe2_x), .pipe2_y(pipe2_y),
        .score_pulse(score_pulse), .score(score), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_p1x = 710; m_p2x = 1065; m_p1y = 240; m_p2y = 320;
        m_score = 0; m_pulse = 0; m_lfsr = 8'hA5;
    endtask

    // Moves one pipe by a frame; returns 1 if it passed the bird.
    task automatic move_pipe(inout int x, inout int y, input int rnd, output int hit);
        hit = 0;
        if (x < 2) begin
            x = 710;
            y = 150 + rnd;
        end else begin
            if (x >= 100 && x - 2 < 100) hit = 1;
            x = x - 2;
        end
    endtask

    task automatic model_step();
        int rnd, h1, h2;
        logic [7:0] l;
        rnd = m_lfsr;
        m_pulse = 0;
        if (restart) begin
            m_mode = 0; m_p1x = 710; m_p2x = 1065; m_p1y = 240; m_p2y = 320; m_score = 0;
        end else if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            if (collision) m_mode = 2;
            else if (frame_tick) begin
                move_pipe(m_p1x, m_p1y, rnd, h1);
                move_pipe(m_p2x, m_p2y, rnd, h2);
                m_score = (m_score + h1 + h2 > 255) ? 255 : m_score + h1 + h2;
                m_pulse = (h1 + h2 > 0) ? 1 : 0;
            end
        end
        l = 8'(m_lfsr);
        m_lfsr = {24'd0, l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endtask

    task automatic cyc(input bit st, input bit rs, input bit col, input bit ft);
        start = st; restart = rs; collision = col; frame_tick = ft;
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pipe1_x", int'(pipe1_x), m_p1x);
            chk("pipe1_y", int'(pipe1_y), m_p1y);
            chk("pipe2_x", int'(pipe2_x), m_p2x);
            chk("pipe2_y", int'(pipe2_y), m_p2y);
            chk("score", int'(score), m_score);
            chk("score_pulse", int'(score_pulse), m_pulse);
            chk("running", int'(running), (m_mode == 1) ? 1 : 0);
        end
    end

    initial begin
        model_reset();
        #12;
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("lit_reset_p1x", int'(pipe1_x), 710);
        chk("lit_reset_p2x", int'(pipe2_x), 1065);
        chk("lit_reset_p1y", int'(pipe1_y), 240);
        chk("lit_reset_p2y", int'(pipe2_y), 320);
        chk("lit_reset_run", int'(running), 0);

        ticks(3);
        chk("lit_wait_hold", int'(pipe1_x), 710);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_run", int'(running), 1);
        ticks(10);
        chk("lit_10_p1x", int'(pipe1_x), 690);
        chk("lit_10_p2x", int'(pipe2_x), 1045);
        chk("lit_10_score", int'(score), 0);
        ticks(295);
        chk("lit_305_p1x", int'(pipe1_x), 100);
        ticks(1);
        chk("lit_cross_p1x", int'(pipe1_x), 98);
        chk("lit_cross_pulse", int'(score_pulse), 1);
        chk("lit_cross_score", int'(score), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_pulse_once", int'(score_pulse), 0);
        ticks(49);
        chk("lit_p1x_zero", int'(pipe1_x), 0);
        ticks(1);
        chk("lit_respawn_p1x", int'(pipe1_x), 710);
        chk("lit_respawn_yrange", (pipe1_y >= 151 && pipe1_y <= 405) ? 1 : 0, 1);
        chk("lit_respawn_p2x", int'(pipe2_x), 353);

        // randomized play
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 99) < 10, $urandom_range(0, 999) < 4,
                $urandom_range(0, 999) < 6, $urandom_range(0, 1) == 1);
        end

        // long run to saturate the score
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(46000);
        chk("lit_score_sat", int'(score), 255);

        // collision with a simultaneous tick freezes the layout
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(155);
        chk("lit_p1x_400", int'(pipe1_x), 400);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("lit_col_p1x", int'(pipe1_x), 400);
        chk("lit_col_run", int'(running), 0);
        ticks(20);
        chk("lit_stop_p1x", int'(pipe1_x), 400);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("lit_restart_run", int'(running), 0);
        chk("lit_restart_p1x", int'(pipe1_x), 710);
        chk("lit_restart_p2x", int'(pipe2_x), 1065);
        chk("lit_restart_score", int'(score), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_restart_start", int'(running), 1);

        // asynchronous reset between edges
        ticks(20);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("lit_areset_p1x", int'(pipe1_x), 710);
        chk("lit_areset_p2x", int'(pipe2_x), 1065);
        chk("lit_areset_p1y", int'(pipe1_y), 240);
        chk("lit_areset_run", int'(running), 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(356);
        chk("lit_post_reset_p1x", int'(pipe1_x), 710);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
Generates the two scrolling pipe obstacles that feed the collision detector. Outputs each pipe's right-edge x and gap-bottom y in screen pixels (640x480), advancing them left once per frame tick. Respawns each pipe off-screen right with a pseudo-random gap height once it leaves the screen. Counts pipes the bird has cleared and freezes all motion when the collision detector reports a hit.

Parameters:
RESPAWN_X, 710, x given to a pipe at init and on respawn (SCREEN_W 640 + pipe width 70)
PIPE_SPACING, 355, initial x offset of pipe2 relative to pipe1
SPEED, 2, pixels moved per frame tick
BIRD_X, 100, fixed bird x used for scoring
GAP_BASE, 150, added to 8-bit LFSR value to form respawn gap y
PIPE1_Y0, 240, pipe1 gap y after reset/restart
PIPE2_Y0, 320, pipe2 gap y after reset/restart

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high; forces reset state immediately
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  begin scrolling (flap/key press)
restart  in  1  return to waiting with initial layout
collision  in  1  level from collision detector; high = bird dead
pipe1_x  out  11  pipe1 right edge x
pipe1_y  out  11  pipe1 gap bottom y (gap spans y-100..y)
pipe2_x  out  11  pipe2 right edge x
pipe2_y  out  11  pipe2 gap bottom y
score_pulse  out  1  one-cycle pulse when a pipe passes the bird
score  out  8  cleared-pipe count, saturating at 255
running  out  1  high in RUN state

Behaviour:
- States: WAIT, RUN, STOP. Reset -> WAIT.
- Reset/restart values: pipe1_x=RESPAWN_X (710), pipe2_x=RESPAWN_X+PIPE_SPACING (1065), pipe1_y=PIPE1_Y0, pipe2_y=PIPE2_Y0, score=0, score_pulse=0, running=0.
- WAIT: outputs hold; start -> RUN next edge.
- RUN: collision -> STOP next edge with no movement applied that edge (collision beats a simultaneous frame_tick). Otherwise, on frame_tick each pipe updates independently:
  - if x < SPEED: x <= RESPAWN_X, y <= GAP_BASE + lfsr (range 151..405).
  - else x <= x - SPEED (unsigned 11-bit; no underflow possible).
- STOP: positions and score frozen; only restart leaves.
- restart in any state -> WAIT next edge, layout/score reinitialised; restart beats start and collision in the same cycle. LFSR is not reseeded by restart.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, advances every clk in all states; never zero. Both pipes respawning on the same tick read the same lfsr value.
- Scoring: in RUN on a moving tick, for each pipe with old x >= BIRD_X and new x < BIRD_X (non-respawn case), assert score_pulse for exactly that cycle and increment score. Two pipes crossing on the same tick add 2 (saturating) with a single pulse. score stops at 255.
- Latency: position outputs registered, valid the cycle after the tick edge; score_pulse coincident with the updated x.
- Asynchronous reset mid-RUN: all outputs return to reset values immediately, independent of clk.

Test Plan:
- Reset, start, 10 frame_ticks -> pipe1_x=690, pipe2_x=1045, running=1, score=0.
- Run pipe1 from 710: after 305 ticks x=100; next tick x=98 with score_pulse=1 for one cycle and score=1.
- Run until pipe1_x=0: next tick pipe1_x=710, pipe1_y=150+lfsr within 151..405, pipe2_x unchanged by respawn.
- Assert collision together with frame_tick at pipe1_x=400 -> STOP, pipe1_x stays 400 for 20 further ticks, running=0.
- In STOP assert restart and start in the same cycle -> WAIT with pipe1_x=710, pipe2_x=1065, score=0. A later start -> RUN.
- Assert reset asynchronously between clk edges mid-RUN -> outputs at reset values before the next edge. LFSR reseeded to 8'hA5.
